branch_predictor_gshare_spec: RTL



---
 rtl/branch_predictor_gshare_spec_pkg.sv | 22 ++
 rtl/branch_predictor_gshare_spec_table.sv | 58 +++++
 rtl/branch_predictor_gshare_spec.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_spec_pkg.sv
// Shared types for the gshare direction predictor: branch outcome, predictor
// lifecycle state and PHT write operations.
package branch_predictor_gshare_spec_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        PRED_INIT  = 1'b0,
        PRED_READY = 1'b1
    } pred_state_e;

    // INIT writes the weakly-not-taken value; INC/DEC are saturating training steps
    typedef enum logic [1:0] {
        PHT_WR_INIT = 2'd0,
        PHT_WR_INC  = 2'd1,
        PHT_WR_DEC  = 2'd2
    } pht_wr_op_e;

endpackage

// File: rtl/branch_predictor_gshare_spec_table.sv
// Pattern history table of saturating counters: one combinational read port for
// prediction and one read-modify-write port for training or the init sweep.
module bp_sat_counter_table
    import branch_predictor_gshare_spec_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    output logic [CNT_WIDTH-1:0]  o_rd_cnt,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_idx,
    input  pht_wr_op_e            i_wr_op
);

    localparam int                   PHT_SIZE = 1 << INDEX_BITS;
    localparam logic [CNT_WIDTH-1:0] WEAK_NT  = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic [CNT_WIDTH-1:0] pht_q [PHT_SIZE];
    logic [CNT_WIDTH-1:0] wr_data_d;
    logic [CNT_WIDTH-1:0] wr_old;

    function automatic logic [CNT_WIDTH-1:0] sat_step(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 up
    );
        logic [CNT_WIDTH-1:0] res;
        res = cnt;
        if (up && (cnt != CNT_MAX)) begin
            res = cnt + CNT_WIDTH'(1);
        end else if (!up && (cnt != '0)) begin
            res = cnt - CNT_WIDTH'(1);
        end
        return res;
    endfunction

    // Prediction reads the pre-update value; a same-cycle write lands next cycle
    assign o_rd_cnt = pht_q[i_rd_idx];
    assign wr_old   = pht_q[i_wr_idx];

    always_comb begin
        wr_data_d = WEAK_NT;
        unique case (i_wr_op)
            PHT_WR_INC: wr_data_d = sat_step(wr_old, 1'b1);
            PHT_WR_DEC: wr_data_d = sat_step(wr_old, 1'b0);
            default:    wr_data_d = WEAK_NT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            pht_q[i_wr_idx] <= wr_data_d;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare_spec.sv
// Gshare direction predictor with speculative global history, misprediction
// repair of the history from the returned snapshot, and a reset-time PHT sweep.
module branch_predictor_gshare_spec
    import branch_predictor_gshare_spec_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 10,
    parameter int HIST_LEN   = 10,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_ready,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output BranchOutcome          o_req_prediction,
    output logic [HIST_LEN-1:0]   o_req_history,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  logic [HIST_LEN-1:0]   i_fb_history,
    input  BranchOutcome          i_fb_prediction,
    input  BranchOutcome          i_fb_outcome,
    output logic [31:0]           o_mispredict_cnt,
    output logic [31:0]           o_branch_cnt
);

    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;
    localparam logic [31:0]           STAT_MAX = '1;

    pred_state_e           state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [HIST_LEN-1:0]   ghr_q, ghr_d;
    logic [31:0]           mis_cnt_q, mis_cnt_d;
    logic [31:0]           br_cnt_q, br_cnt_d;

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fb_idx;
    logic [CNT_WIDTH-1:0]  rd_cnt;
    logic                  pred_taken;
    logic                  fb_mispredict;
    logic                  fb_taken;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    pht_wr_op_e            wr_op;
    logic                  unused_pc_bits;

    function automatic logic [INDEX_BITS-1:0] pht_index(
        input logic [INDEX_BITS-1:0] pc_bits,
        input logic [HIST_LEN-1:0]   hist
    );
        return pc_bits ^ INDEX_BITS'(hist);
    endfunction

    // Shift in the newest outcome at bit 0; also covers HIST_LEN == 1
    function automatic logic [HIST_LEN-1:0] hist_shift(
        input logic [HIST_LEN-1:0] hist,
        input logic                taken
    );
        return HIST_LEN'({hist, taken});
    endfunction

    assign req_idx        = pht_index(i_req_pc[INDEX_BITS+1:2], ghr_q);
    assign fb_idx         = pht_index(i_fb_pc[INDEX_BITS+1:2], i_fb_history);
    assign unused_pc_bits = ^{i_req_pc, i_fb_pc};

    bp_sat_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pht (
        .clk      (clk),
        .i_rd_idx (req_idx),
        .o_rd_cnt (rd_cnt),
        .i_wr_en  (wr_en),
        .i_wr_idx (wr_idx),
        .i_wr_op  (wr_op)
    );

    assign o_ready          = (state_q == PRED_READY);
    assign pred_taken       = o_ready & rd_cnt[CNT_WIDTH-1];
    assign o_req_prediction = pred_taken ? TAKEN : NOT_TAKEN;
    assign o_req_history    = o_ready ? ghr_q : '0;
    assign o_mispredict_cnt = mis_cnt_q;
    assign o_branch_cnt     = br_cnt_q;
    assign fb_taken         = (i_fb_outcome == TAKEN);
    assign fb_mispredict    = (i_fb_prediction != i_fb_outcome);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ghr_d     = ghr_q;
        mis_cnt_d = mis_cnt_q;
        br_cnt_d  = br_cnt_q;
        wr_en     = 1'b0;
        wr_idx    = ptr_q;
        wr_op     = PHT_WR_INIT;

        unique case (state_q)
            PRED_INIT: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + INDEX_BITS'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = PRED_READY;
                end
            end
            PRED_READY: begin
                if (i_req_valid) begin
                    ghr_d = hist_shift(ghr_q, pred_taken);
                end
                if (i_fb_valid) begin
                    wr_en  = 1'b1;
                    wr_idx = fb_idx;
                    wr_op  = fb_taken ? PHT_WR_INC : PHT_WR_DEC;
                    if (br_cnt_q != STAT_MAX) begin
                        br_cnt_d = br_cnt_q + 32'd1;
                    end
                    // The same-cycle request sits on the squashed path, so repair wins
                    if (fb_mispredict) begin
                        ghr_d = hist_shift(i_fb_history, fb_taken);
                        if (mis_cnt_q != STAT_MAX) begin
                            mis_cnt_d = mis_cnt_q + 32'd1;
                        end
                    end
                end
            end
            default: state_d = PRED_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PRED_INIT;
            ptr_q     <= '0;
            ghr_q     <= '0;
            mis_cnt_q <= '0;
            br_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ghr_q     <= ghr_d;
            mis_cnt_q <= mis_cnt_d;
            br_cnt_q  <= br_cnt_d;
        end
    end

endmodule
